ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  out  1  fetch request; imem_req_ready  in  1  memory accepts request.
REQ-005 imem_addr  out  32  fetch address, equal to pc.
REQ-006 imem_rsp_valid  in  1; imem_rsp_data  in  32; imem_rsp_err  in  1: fetch response.
REQ-007 inst_valid  out  1; inst_ready  in  1: handshake toward decode stage.
REQ-008 inst  out  32; inst_pc  out  32: fetched word and its address.
REQ-009 redirect_valid  in  1; redirect_pc  in  32: next-pc override from execute.
REQ-010 halt  in  1  stop request (decode stop_sim).
REQ-011 perf_fetch_cnt  out  32; perf_stall_cnt  out  32.

Function
REQ-012 FSM states IDLE, REQ, WAIT, HOLD, HALTED; imem_req_valid SHALL be 1 only in REQ, inst_valid only in HOLD.
REQ-013 IDLE -> REQ unconditionally on the first edge after reset release.
REQ-014 REQ: imem_req_valid=1, imem_addr=pc; imem_req_ready=1 -> WAIT.
REQ-015 WAIT: imem_rsp_valid=1 -> capture inst=imem_rsp_data, inst_pc=pc, -> HOLD; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-016 imem_rsp_err=1 with accepted response SHALL capture inst=32'h0010_0073 (ebreak) instead of data.
REQ-017 HOLD: inst, inst_pc stable; inst_valid&inst_ready -> pc<=pc+4, next state HALTED if halt=1 else REQ.
REQ-018 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 redirect_valid SHALL have priority over every other event in IDLE/REQ/HOLD: pc<={redirect_pc[31:2],2'b00}, -> REQ, no pc+4 even if handshake coincides.
REQ-020 redirect_valid in WAIT: pc<=redirect target, set drop flag, stay WAIT; next accepted response SHALL be discarded, flag cleared, -> REQ.
REQ-021 redirect and response in same WAIT cycle: response discarded, -> REQ with new pc.
REQ-022 HALTED SHALL be sticky until reset; redirect, responses ignored; no requests issued.
REQ-023 Latency: request accept to inst_valid = response latency + 1 cycle; minimum fetch period 3 cycles.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, drop flag=0, inst=0, inst_pc=0, all outputs 0, counters 0, including mid-transaction; a pending memory response after reset is ignored.

Configuration
REQ-025 With IFU_PERF_EN defined: perf_fetch_cnt increments per inst handshake, perf_stall_cnt per cycle in REQ or WAIT, both wrapping; without it both outputs SHALL be constant 0 and no counter registers exist.

Structure
REQ-026 State enum encoding and RESET_PC default SHALL live in the shared npc package; EBREAK constant 32'h0010_0073 shared with decode.
REQ-027 Single module; no sub-module.

Verification
REQ-028 Reset release, memory ready immediately, 1-cycle rsp 32'h0010_0093, inst_ready=1 -> imem_addr 8000_0000, inst_valid with inst_pc 8000_0000, next request 8000_0004.
REQ-029 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new request, pc unchanged.
REQ-030 redirect to 8000_0102 during WAIT, then rsp -> response never presented, next request address 8000_0100.
REQ-031 imem_rsp_err=1 -> inst=32'h0010_0073; halt=1 at handshake -> HALTED, imem_req_valid stays 0 for 20 cycles.
REQ-032 rst_n low mid-WAIT, then rsp_valid pulse -> outputs 0, restart fetch at RESET_PC; with IFU_PERF_EN, 3 fetches at 0-wait memory -> perf_fetch_cnt=3.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset vector default, EBREAK word.
// Decode imports EBREAK from here as well.
package ifu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4
   } ifu_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] EBREAK       = 32'h0010_0073;

   // Fetch addresses are always word aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-stage bundle: imem request/response, decode handshake, redirect/halt, perf counters.
// master = ifu side, slave = memory/decode/execute side.
interface ifu_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;

   modport master (
      output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
             perf_fetch_cnt, perf_stall_cnt,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
             inst_ready, redirect_valid, redirect_pc, halt
   );

   modport slave (
      input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
             perf_fetch_cnt, perf_stall_cnt,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
             inst_ready, redirect_valid, redirect_pc, halt
   );

endinterface

// File: rtl/ifu.sv
// Instruction fetch: one outstanding imem request, result held until decode takes it.
// Latency: request accept to inst_valid = rsp latency + 1; min period 3 cycles; stalls on imem_req_ready/inst_ready.
// Optional IFU_PERF_EN adds fetch/stall counters (outputs tie to 0 otherwise).
module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input logic   clk,
   input logic   rst_n,
   ifu_if.master bus
);

   ifu_state_t  state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        drop, drop_nxt;
   logic [31:0] inst_q, inst_pc_q;
   logic        capture;
   logic        handshake;

   assign handshake = (state == ST_HOLD) && bus.inst_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      drop_nxt  = drop;
      capture   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
            if (bus.redirect_valid) pc_nxt = align_pc(bus.redirect_pc);
         end
         ST_REQ: begin
            if (bus.redirect_valid) begin
               pc_nxt = align_pc(bus.redirect_pc);
            end else if (bus.imem_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A redirect turns the in-flight response stale; if it has not
            // arrived yet, remember to throw it away when it does.
            if (bus.redirect_valid) begin
               pc_nxt = align_pc(bus.redirect_pc);
               if (bus.imem_rsp_valid) begin
                  drop_nxt  = 1'b0;
                  state_nxt = ST_REQ;
               end else begin
                  drop_nxt = 1'b1;
               end
            end else if (bus.imem_rsp_valid) begin
               drop_nxt  = 1'b0;
               capture   = !drop;
               state_nxt = drop ? ST_REQ : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.redirect_valid) begin
               pc_nxt    = align_pc(bus.redirect_pc);
               state_nxt = ST_REQ;
            end else if (handshake) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = bus.halt ? ST_HALTED : ST_REQ;
            end
         end
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         drop  <= drop_nxt;
         if (capture) begin
            inst_q    <= bus.imem_rsp_err ? EBREAK : bus.imem_rsp_data;
            inst_pc_q <= pc;
         end
      end
   end

   assign bus.imem_req_valid = (state == ST_REQ);
   assign bus.imem_addr      = (state == ST_REQ) ? pc : '0;
   assign bus.inst_valid     = (state == ST_HOLD);
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;

`ifdef IFU_PERF_EN
   logic [31:0] fetch_cnt, stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
         if (state == ST_REQ || state == ST_WAIT) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.perf_fetch_cnt = fetch_cnt;
   assign bus.perf_stall_cnt = stall_cnt;
`else
   assign bus.perf_fetch_cnt = '0;
   assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: fetch timing, decode backpressure, redirects, error/halt, reset mid-fetch.
module tb_ifu;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ifu_if bus ();

   ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered with the DUT in REQ; leaves it in HOLD showing the fetched word.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                        input logic err, input logic [31:0] exp_inst);
      check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      check("req_addr", bus.imem_addr, addr);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      bus.imem_rsp_err   = err;
      check("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_err   = 1'b0;
      check("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("inst", bus.inst, exp_inst);
      check("inst_pc", bus.inst_pc, addr);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
      check({tag, "_addr"}, bus.imem_addr, 32'd0);
      check({tag, "_inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
      check({tag, "_inst"}, bus.inst, 32'd0);
      check({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
      check({tag, "_perf_fetch"}, bus.perf_fetch_cnt, 32'd0);
      check({tag, "_perf_stall"}, bus.perf_stall_cnt, 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.imem_rsp_err   = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.halt           = 1'b0;

      // Reset state
      #1;
      check_idle_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;
      check("idle_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      tick();

      // First fetch at the reset vector, then decode stalls for 5 cycles
      fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 32'h0010_0093);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
         check("stall_inst", bus.inst, 32'h0010_0093);
         check("stall_pc", bus.inst_pc, 32'h8000_0000);
         check("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      check("after_hs_valid", {31'd0, bus.inst_valid}, 32'd0);
      fetch(32'h8000_0004, 32'h0000_0013, 1'b0, 32'h0000_0013);
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;

      // Redirect during WAIT, response arrives later and must be dropped
      check("req8_addr", bus.imem_addr, 32'h8000_0008);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0102;
      tick();
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      check("drop_wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      tick();
      bus.imem_rsp_valid = 1'b0;
      check("drop_no_inst", {31'd0, bus.inst_valid}, 32'd0);
      check("drop_inst_kept", bus.inst, 32'h0000_0013);

      // Redirect and response in the same WAIT cycle
      bus.imem_req_ready = 1'b1;
      check("redir_req_addr", bus.imem_addr, 32'h8000_0100);
      tick();
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0200;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
      tick();
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      check("same_cyc_no_inst", {31'd0, bus.inst_valid}, 32'd0);

      // Redirect beats a coinciding handshake and halt in HOLD
      fetch(32'h8000_0200, 32'h0000_1111, 1'b0, 32'h0000_1111);
      bus.inst_ready     = 1'b1;
      bus.halt           = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0300;
      tick();
      bus.inst_ready     = 1'b0;
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      check("hold_redir_addr", bus.imem_addr, 32'h8000_0300);

      // Redirect in REQ, then pc+4 wraps past the top of memory
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFF;
      tick();
      bus.redirect_valid = 1'b0;
      fetch(32'hFFFF_FFFC, 32'h0000_2222, 1'b0, 32'h0000_2222);
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;

      // Fetch error becomes EBREAK; halt on its handshake is sticky
      fetch(32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0010_0073);
      bus.inst_ready = 1'b1;
      bus.halt       = 1'b1;
      tick();
      bus.halt           = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0000;
      for (int i = 0; i < 20; i++) begin
         bus.imem_rsp_valid = i[0];
         check("halted_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
         check("halted_no_inst", {31'd0, bus.inst_valid}, 32'd0);
         tick();
      end
      bus.imem_rsp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b0;
      check("halted_inst_kept", bus.inst, 32'h0010_0073);

      // Reset release after halt, then reset asserted mid-WAIT
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("restart_addr", bus.imem_addr, 32'h8000_0000);
      tick();
      bus.imem_req_ready = 1'b0;
      check("mid_wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_wait_rst");
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hCAFE_F00D;
      tick();
      bus.imem_rsp_valid = 1'b0;
      rst_n = 1'b1;
      check("post_rst_inst", bus.inst, 32'd0);
      tick();

      // Three zero-wait fetches from the reset vector
      bus.inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch(32'h8000_0000 + 32'(4 * i), 32'h0000_0100 + 32'(i), 1'b0,
               32'h0000_0100 + 32'(i));
         tick();
      end
      bus.inst_ready = 1'b0;
      check("addr_after_3", bus.imem_addr, 32'h8000_000C);
`ifdef IFU_PERF_EN
      check("perf_fetch", bus.perf_fetch_cnt, 32'd3);
      check("perf_stall", bus.perf_stall_cnt, 32'd6);
`else
      check("perf_fetch_off", bus.perf_fetch_cnt, 32'd0);
      check("perf_stall_off", bus.perf_stall_cnt, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
